btb_assoc: RTL and testbench
============================

BTB_ASSOC -- requirements
Module: btb_assoc

Interface
REQ-001 Parameter SETS, default 256, number of sets; power of two, 2..1024.
REQ-002 Parameter WAYS, default 2, ways per set; 1, 2 or 4.
REQ-003 Derived IDX_W = log2(SETS); set index = pc[IDX_W+1:2].
REQ-004 clk  input  1  clock, all state updates on rising edge.
REQ-005 resetn  input  1  synchronous, active-low reset.
REQ-006 wen  input  1  write/update entry for pc_w.
REQ-007 pc_w  input  32  branch PC to write (full-PC tag).
REQ-008 target_w  input  32  branch target to write.
REQ-009 type_w  input  2  branch type: 00 cond, 01 uncond jump, 10 call, 11 return.
REQ-010 rm  input  1  invalidate entry matching pc_rm.
REQ-011 pc_rm  input  32  PC to invalidate.
REQ-012 pc_r  input  32  lookup PC.
REQ-013 hit_r  output  1  lookup hit.
REQ-014 target_r  output  32  target of hit entry, 0 on miss.
REQ-015 type_r  output  2  type of hit entry, 0 on miss.
REQ-016 way_r  output  log2(WAYS) (min 1)  way of hit entry, 0 on miss.
REQ-017 ready  output  1  table initialised, lookups/updates accepted.

Function
REQ-018 Each entry SHALL hold valid, tag[31:0], target[31:0], type[1:0]; each set SHALL hold a round-robin victim pointer (log2(WAYS) bits).
REQ-019 FSM states: INIT, RUN; INIT clears valid and victim pointer of one set per cycle, index 0 upward, via a sweep counter.
REQ-020 INIT SHALL last exactly SETS cycles, then move to RUN; ready=1 only in RUN.
REQ-021 Lookup SHALL be combinational: hit when a valid way in set(pc_r) has tag==pc_r; at most one way matches.
REQ-022 While ready=0: hit_r=0, target_r=0, type_r=0, way_r=0; wen and rm ignored.
REQ-023 Write (RUN, wen=1): if pc_w already present in its set, overwrite target/type in that way; victim pointer unchanged.
REQ-024 Else allocate the lowest-numbered invalid way; victim pointer unchanged.
REQ-025 Else replace the way at the victim pointer, then increment the pointer modulo WAYS.
REQ-026 Remove (RUN, rm=1): clear valid of the way matching pc_rm; no match -> no state change.
REQ-027 wen and rm same cycle, same PC: write wins, entry valid afterwards; different PCs: both take effect.
REQ-028 Bypass: wen=1 and pc_r==pc_w same cycle -> hit_r=1, target_r=target_w, type_r=type_w, way_r=way being written.
REQ-029 Bypass: rm=1, wen=0, pc_r==pc_rm same cycle -> hit_r=0 and all other outputs 0.
REQ-030 With WAYS=1, the pointer SHALL be constant 0 and replacement SHALL overwrite way 0.

Reset
REQ-031 resetn=0 at a clock edge SHALL force INIT, sweep counter=0, ready=0, and abort any pending write/remove that cycle.
REQ-032 Asserting resetn in RUN or mid-INIT SHALL restart the full SETS-cycle sweep.
REQ-033 Table contents are don't-care during INIT; outputs SHALL be zero per REQ-022.

Verification
REQ-034 Reset released at cycle 0 (SETS=256) -> ready=0 for cycles 0..255, ready=1 from cycle 256; hit_r=0 throughout INIT for any pc_r.
REQ-035 Write pc 0x00400010 -> 0x00400100 type 01; next cycle lookup -> hit_r=1, target_r=0x00400100, type_r=01, way_r=0.
REQ-036 Same set, WAYS=2: write 0x00000010, 0x00000410, then 0x00000810 -> third replaces way 0; 0x00000010 misses, other two hit; fourth distinct PC 0x00000C10 replaces way 1.
REQ-037 Same cycle wen pc_w=pc_r=0x1000 target 0x2000 -> hit_r=1, target_r=0x2000 that cycle; same cycle rm+wen on 0x1000 -> still hits next cycle.
REQ-038 rm pc 0x00400010 after REQ-035 -> hit_r=0 combinationally that cycle and every later cycle; other way in set unaffected.
REQ-039 resetn pulsed low for 1 cycle mid-run after 3 valid writes -> ready=0 for 256 cycles, then all three lookups miss.

Source files
------------

// File: rtl/btb_assoc_if.sv
// Request/response bundle for the set-associative BTB: write, remove and lookup ports.
interface btb_assoc_if #(
  parameter int unsigned WAYS = 2
);
  localparam int unsigned WAY_W = (WAYS > 1) ? $clog2(WAYS) : 1;

  logic             wen;
  logic [31:0]      pc_w;
  logic [31:0]      target_w;
  logic [1:0]       type_w;
  logic             rm;
  logic [31:0]      pc_rm;
  logic [31:0]      pc_r;
  logic             hit_r;
  logic [31:0]      target_r;
  logic [1:0]       type_r;
  logic [WAY_W-1:0] way_r;
  logic             ready;

  modport master (
    output wen, pc_w, target_w, type_w, rm, pc_rm, pc_r,
    input  hit_r, target_r, type_r, way_r, ready
  );

  modport slave (
    input  wen, pc_w, target_w, type_w, rm, pc_rm, pc_r,
    output hit_r, target_r, type_r, way_r, ready
  );
endinterface

// File: rtl/btb_assoc.sv
// Set-associative branch target buffer with full-PC tags, round-robin replacement
// and a one-set-per-cycle invalidation sweep after reset.
module btb_assoc #(
  parameter int unsigned SETS = 256,
  parameter int unsigned WAYS = 2
) (
  input logic       clk,
  input logic       resetn,
  btb_assoc_if.slave bus
);
  localparam int unsigned IDX_W = $clog2(SETS);
  localparam int unsigned WAY_W = (WAYS > 1) ? $clog2(WAYS) : 1;

  typedef struct packed {
    logic        valid;
    logic [31:0] tag;
    logic [31:0] target;
    logic [1:0]  btype;
  } entry_t;

  typedef enum logic [0:0] {StInit, StRun} state_e;

  state_e           state_q, state_d;
  logic [IDX_W-1:0] sweep_q, sweep_d;
  entry_t           entry_q [SETS][WAYS];
  entry_t           entry_d [SETS][WAYS];
  logic [WAY_W-1:0] ptr_q [SETS];
  logic [WAY_W-1:0] ptr_d [SETS];

  logic [IDX_W-1:0] idx_r, idx_w, idx_rm;
  logic [WAY_W:0]   r_find, w_find, rm_find;
  logic             w_free;
  logic [WAY_W-1:0] w_free_way;
  logic [WAY_W-1:0] wr_way;
  logic             wr_repl;
  logic             run;

  // Returns {hit, way}; tags are unique within a set so at most one way matches.
  function automatic logic [WAY_W:0] find(input entry_t set_e [WAYS], input logic [31:0] pc);
    logic [WAY_W:0] res;
    res = '0;
    for (int unsigned w = 0; w < WAYS; w++) begin
      if (set_e[w].valid && (set_e[w].tag == pc)) begin
        res = {1'b1, WAY_W'(w)};
      end
    end
    return res;
  endfunction

  assign run    = (state_q == StRun);
  assign idx_r  = bus.pc_r[IDX_W+1:2];
  assign idx_w  = bus.pc_w[IDX_W+1:2];
  assign idx_rm = bus.pc_rm[IDX_W+1:2];

  assign r_find  = find(entry_q[idx_r], bus.pc_r);
  assign w_find  = find(entry_q[idx_w], bus.pc_w);
  assign rm_find = find(entry_q[idx_rm], bus.pc_rm);

  // Write way is chosen from the pre-update set, before any same-cycle remove.
  always_comb begin
    w_free     = 1'b0;
    w_free_way = '0;
    for (int w = int'(WAYS) - 1; w >= 0; w--) begin
      if (!entry_q[idx_w][w].valid) begin
        w_free     = 1'b1;
        w_free_way = WAY_W'(w);
      end
    end
    wr_repl = 1'b0;
    if (w_find[WAY_W]) begin
      wr_way = w_find[WAY_W-1:0];
    end else if (w_free) begin
      wr_way = w_free_way;
    end else begin
      wr_way  = ptr_q[idx_w];
      wr_repl = 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    sweep_d = sweep_q;
    entry_d = entry_q;
    ptr_d   = ptr_q;
    if (!resetn) begin
      state_d = StInit;
      sweep_d = '0;
    end else if (state_q == StInit) begin
      for (int unsigned w = 0; w < WAYS; w++) begin
        entry_d[sweep_q][w].valid = 1'b0;
      end
      ptr_d[sweep_q] = '0;
      sweep_d        = sweep_q + 1'b1;
      if (sweep_q == IDX_W'(SETS - 1)) begin
        state_d = StRun;
      end
    end else begin
      // Remove first so that a same-PC write lands afterwards and leaves the entry valid.
      if (bus.rm && rm_find[WAY_W]) begin
        entry_d[idx_rm][rm_find[WAY_W-1:0]].valid = 1'b0;
      end
      if (bus.wen) begin
        entry_d[idx_w][wr_way] = '{valid: 1'b1, tag: bus.pc_w, target: bus.target_w,
                                   btype: bus.type_w};
        if (wr_repl) begin
          ptr_d[idx_w] = (WAYS == 1) ? '0 : ptr_q[idx_w] + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q <= StInit;
      sweep_q <= '0;
    end else begin
      state_q <= state_d;
      sweep_q <= sweep_d;
    end
  end

  // Table contents are don't-care until the sweep has cleared them, so no reset here.
  always_ff @(posedge clk) begin
    entry_q <= entry_d;
    ptr_q   <= ptr_d;
  end

  always_comb begin
    bus.hit_r    = 1'b0;
    bus.target_r = '0;
    bus.type_r   = '0;
    bus.way_r    = '0;
    if (run) begin
      if (bus.wen && (bus.pc_r == bus.pc_w)) begin
        bus.hit_r    = 1'b1;
        bus.target_r = bus.target_w;
        bus.type_r   = bus.type_w;
        bus.way_r    = wr_way;
      end else if (bus.rm && (bus.pc_r == bus.pc_rm)) begin
        bus.hit_r = 1'b0;
      end else if (r_find[WAY_W]) begin
        bus.hit_r    = 1'b1;
        bus.target_r = entry_q[idx_r][r_find[WAY_W-1:0]].target;
        bus.type_r   = entry_q[idx_r][r_find[WAY_W-1:0]].btype;
        bus.way_r    = r_find[WAY_W-1:0];
      end
    end
  end

  assign bus.ready = run;

endmodule

// File: tb/tb_btb_assoc.sv
// Bench for btb_assoc: directed vector table for the documented scenarios plus random
// traffic checked against a slot-array reference model.
module tb_btb_assoc;
  localparam int unsigned SETS = 256;
  localparam int unsigned WAYS = 2;
  localparam int unsigned WW   = (WAYS > 1) ? $clog2(WAYS) : 1;
  localparam int unsigned OW   = 36 + WW;

  logic clk;
  logic resetn;

  btb_assoc_if #(.WAYS(WAYS)) bus ();

  btb_assoc #(.SETS(SETS), .WAYS(WAYS)) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp;
  int n_bad;

  // Reference model: per set a row of slots and a round-robin counter.
  bit          m_valid [SETS][WAYS];
  logic [31:0] m_tag   [SETS][WAYS];
  logic [31:0] m_tgt   [SETS][WAYS];
  logic [1:0]  m_typ   [SETS][WAYS];
  int          m_ptr   [SETS];
  int          m_left;

  function automatic int set_of(input logic [31:0] pc);
    return int'(pc / 4) % int'(SETS);
  endfunction

  function automatic void model_reset();
    for (int s = 0; s < int'(SETS); s++) begin
      m_ptr[s] = 0;
      for (int w = 0; w < int'(WAYS); w++) m_valid[s][w] = 1'b0;
    end
    m_left = SETS;
  endfunction

  function automatic int model_victim(input logic [31:0] pc, output bit repl);
    int s;
    s    = set_of(pc);
    repl = 1'b0;
    for (int w = 0; w < int'(WAYS); w++) if (m_valid[s][w] && m_tag[s][w] == pc) return w;
    for (int w = 0; w < int'(WAYS); w++) if (!m_valid[s][w]) return w;
    repl = 1'b1;
    return m_ptr[s];
  endfunction

  function automatic logic [OW-1:0] model_out();
    int s;
    int v;
    bit rp;
    if (m_left != 0) return '0;
    if (bus.wen && bus.pc_r == bus.pc_w) begin
      v = model_victim(bus.pc_w, rp);
      return {1'b1, 1'b1, bus.target_w, bus.type_w, WW'(v)};
    end
    if (bus.rm && bus.pc_r == bus.pc_rm) return {1'b1, {(OW-1){1'b0}}};
    s = set_of(bus.pc_r);
    for (int w = 0; w < int'(WAYS); w++) begin
      if (m_valid[s][w] && m_tag[s][w] == bus.pc_r) begin
        return {1'b1, 1'b1, m_tgt[s][w], m_typ[s][w], WW'(w)};
      end
    end
    return {1'b1, {(OW-1){1'b0}}};
  endfunction

  function automatic void model_commit();
    int s;
    int v;
    bit rp;
    if (!resetn) begin
      model_reset();
    end else if (m_left > 0) begin
      m_left--;
    end else begin
      v = model_victim(bus.pc_w, rp);
      if (bus.rm) begin
        s = set_of(bus.pc_rm);
        for (int w = 0; w < int'(WAYS); w++)
          if (m_valid[s][w] && m_tag[s][w] == bus.pc_rm) m_valid[s][w] = 1'b0;
      end
      if (bus.wen) begin
        s = set_of(bus.pc_w);
        m_valid[s][v] = 1'b1;
        m_tag[s][v]   = bus.pc_w;
        m_tgt[s][v]   = bus.target_w;
        m_typ[s][v]   = bus.type_w;
        if (rp) m_ptr[s] = (m_ptr[s] + 1) % int'(WAYS);
      end
    end
  endfunction

  function automatic logic [OW-1:0] dut_out();
    return {bus.ready, bus.hit_r, bus.target_r, bus.type_r, bus.way_r};
  endfunction

  // Called just after a falling edge with inputs already driven.
  task automatic run_cycle(input string nm, input bit use_exp, input logic [OW-1:0] exp_v);
    logic [OW-1:0] got;
    logic [OW-1:0] want;
    #1;
    got  = dut_out();
    want = use_exp ? exp_v : model_out();
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got rdy=%0b hit=%0b tgt=%h typ=%0d way=%0d, want rdy=%0b hit=%0b tgt=%h typ=%0d way=%0d",
               nm, got[OW-1], got[OW-2], got[OW-3 -: 32], got[WW+1 -: 2], got[WW-1:0],
               want[OW-1], want[OW-2], want[OW-3 -: 32], want[WW+1 -: 2], want[WW-1:0]);
    end
    model_commit();
    @(posedge clk);
    @(negedge clk);
  endtask

  function automatic logic [31:0] rpc();
    return (32'($urandom_range(0, 5)) << 10) | (32'($urandom_range(0, 3)) << 2);
  endfunction

  task automatic idle_inputs();
    bus.wen = 1'b0; bus.pc_w = '0; bus.target_w = '0; bus.type_w = '0;
    bus.rm = 1'b0; bus.pc_rm = '0; bus.pc_r = '0;
  endtask

  // Sweep with live-looking traffic; optionally pulse reset part-way through.
  task automatic do_init(input int mid_rst);
    for (int i = 0; i < 3 * int'(SETS) && m_left > 0; i++) begin
      bus.wen = 1'b1; bus.pc_w = rpc(); bus.target_w = $urandom; bus.type_w = 2'($urandom);
      bus.rm = 1'($urandom); bus.pc_rm = rpc(); bus.pc_r = bus.pc_w;
      resetn = (i == mid_rst) ? 1'b0 : 1'b1;
      run_cycle("init", 1'b0, '0);
    end
    resetn = 1'b1;
    idle_inputs();
    run_cycle("init_done", 1'b1, {1'b1, {(OW-1){1'b0}}});
  endtask

  typedef struct {
    bit          wen;
    logic [31:0] pc_w;
    logic [31:0] tgt_w;
    logic [1:0]  typ_w;
    bit          rm;
    logic [31:0] pc_rm;
    logic [31:0] pc_r;
    bit          e_hit;
    logic [31:0] e_tgt;
    logic [1:0]  e_typ;
    int          e_way;
  } vec_t;

  function automatic vec_t mk(bit wen, logic [31:0] pw, logic [31:0] tw, logic [1:0] yw,
                              bit rm, logic [31:0] prm, logic [31:0] pr,
                              bit eh, logic [31:0] et, logic [1:0] ey, int ew);
    vec_t v;
    v = '{wen, pw, tw, yw, rm, prm, pr, eh, et, ey, ew};
    return v;
  endfunction

  vec_t tbl [23];

  logic [31:0] keep_pc [3];

  initial begin
    n_cmp = 0;
    n_bad = 0;
    idle_inputs();
    resetn = 1'b0;
    model_reset();
    @(posedge clk);
    @(negedge clk);
    resetn = 1'b1;

    // Full sweep, restarted by a reset pulse at sweep step 100.
    do_init(100);

    tbl[0]  = mk(1, 32'h00400010, 32'h00400100, 2'd1, 0, 0, 32'h00400010, 1, 32'h00400100, 1, 0);
    tbl[1]  = mk(0, 0, 0, 0, 0, 0, 32'h00400010, 1, 32'h00400100, 1, 0);
    tbl[2]  = mk(1, 32'h00400410, 32'h55, 2'd2, 0, 0, 32'h00400410, 1, 32'h55, 2, 1);
    tbl[3]  = mk(0, 0, 0, 0, 1, 32'h00400010, 32'h00400010, 0, 0, 0, 0);
    tbl[4]  = mk(0, 0, 0, 0, 0, 0, 32'h00400010, 0, 0, 0, 0);
    tbl[5]  = mk(0, 0, 0, 0, 0, 0, 32'h00400410, 1, 32'h55, 2, 1);
    tbl[6]  = mk(0, 0, 0, 0, 1, 32'h00400410, 32'h00400410, 0, 0, 0, 0);
    tbl[7]  = mk(1, 32'h010, 32'h100, 2'd0, 0, 0, 32'h010, 1, 32'h100, 0, 0);
    tbl[8]  = mk(1, 32'h410, 32'h200, 2'd1, 0, 0, 32'h010, 1, 32'h100, 0, 0);
    tbl[9]  = mk(1, 32'h810, 32'h300, 2'd2, 0, 0, 32'h410, 1, 32'h200, 1, 1);
    tbl[10] = mk(0, 0, 0, 0, 0, 0, 32'h010, 0, 0, 0, 0);
    tbl[11] = mk(0, 0, 0, 0, 0, 0, 32'h810, 1, 32'h300, 2, 0);
    tbl[12] = mk(1, 32'hC10, 32'h400, 2'd3, 0, 0, 32'hC10, 1, 32'h400, 3, 1);
    tbl[13] = mk(0, 0, 0, 0, 0, 0, 32'h410, 0, 0, 0, 0);
    tbl[14] = mk(0, 0, 0, 0, 0, 0, 32'h810, 1, 32'h300, 2, 0);
    tbl[15] = mk(0, 0, 0, 0, 0, 0, 32'hC10, 1, 32'h400, 3, 1);
    tbl[16] = mk(1, 32'h1000, 32'h2000, 2'd0, 0, 0, 32'h1000, 1, 32'h2000, 0, 0);
    tbl[17] = mk(1, 32'h1000, 32'h3000, 2'd1, 1, 32'h1000, 32'h1000, 1, 32'h3000, 1, 0);
    tbl[18] = mk(0, 0, 0, 0, 0, 0, 32'h1000, 1, 32'h3000, 1, 0);
    tbl[19] = mk(0, 0, 0, 0, 1, 32'h5000, 32'h1000, 1, 32'h3000, 1, 0);
    tbl[20] = mk(1, 32'h1400, 32'h77, 2'd2, 1, 32'h1000, 32'h1400, 1, 32'h77, 2, 1);
    tbl[21] = mk(0, 0, 0, 0, 0, 0, 32'h1000, 0, 0, 0, 0);
    tbl[22] = mk(0, 0, 0, 0, 0, 0, 32'h1400, 1, 32'h77, 2, 1);

    for (int i = 0; i < 23; i++) begin
      bus.wen = tbl[i].wen; bus.pc_w = tbl[i].pc_w; bus.target_w = tbl[i].tgt_w;
      bus.type_w = tbl[i].typ_w; bus.rm = tbl[i].rm; bus.pc_rm = tbl[i].pc_rm;
      bus.pc_r = tbl[i].pc_r;
      run_cycle($sformatf("vec%0d", i), 1'b1,
                {1'b1, tbl[i].e_hit, tbl[i].e_tgt, tbl[i].e_typ, WW'(tbl[i].e_way)});
    end

    // Random traffic concentrated on a few sets to exercise replacement.
    for (int i = 0; i < 1500; i++) begin
      bus.wen      = ($urandom_range(0, 9) < 4);
      bus.pc_w     = rpc();
      bus.target_w = $urandom;
      bus.type_w   = 2'($urandom);
      bus.rm       = ($urandom_range(0, 9) < 2);
      bus.pc_rm    = ($urandom_range(0, 3) == 0) ? bus.pc_w : rpc();
      case ($urandom_range(0, 3))
        0:       bus.pc_r = bus.pc_w;
        1:       bus.pc_r = bus.pc_rm;
        default: bus.pc_r = rpc();
      endcase
      run_cycle("rand", 1'b0, '0);
    end

    // Three writes, one-cycle reset pulse in RUN, full sweep, then all must miss.
    keep_pc[0] = 32'h00000020;
    keep_pc[1] = 32'h00000024;
    keep_pc[2] = 32'h00000420;
    for (int i = 0; i < 3; i++) begin
      idle_inputs();
      bus.wen = 1'b1; bus.pc_w = keep_pc[i]; bus.target_w = 32'hABC0 + i; bus.pc_r = keep_pc[i];
      run_cycle("pre_rst_wr", 1'b0, '0);
    end
    idle_inputs();
    bus.pc_r = keep_pc[0];
    run_cycle("pre_rst_hit", 1'b1, {1'b1, 1'b1, 32'hABC0, 2'd0, WW'(0)});
    resetn = 1'b0;
    run_cycle("rst_pulse", 1'b0, '0);
    resetn = 1'b1;
    do_init(-1);
    for (int i = 0; i < 3; i++) begin
      idle_inputs();
      bus.pc_r = keep_pc[i];
      run_cycle("post_rst_miss", 1'b1, {1'b1, {(OW-1){1'b0}}});
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
